// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART requester arbiter.
// Provides the FSM state encoding and the ctrl codes driven towards the UART FSM.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    CLEAR = 2'd3
  } arb_state_e;

  localparam logic [1:0] CTRL_TX   = 2'b01;
  localparam logic [1:0] CTRL_RX   = 2'b10;
  localparam logic [1:0] CTRL_NONE = 2'b00;

  function automatic logic [1:0] ctrl_for_dir(input logic dir);
    return dir ? CTRL_TX : CTRL_RX;
  endfunction

endpackage

// File: rtl/uart_req_arbiter_if.sv
// Bundle of requester-side and UART-side signals seen by the arbiter.
// The slave modport is the arbiter view; master is the requesters plus UART FSM.
interface uart_req_arbiter_if #(
  parameter int NUM_REQ = 4
);
  // Handshake: req[i] is a level held by requester i until it sees done[i] or err[i];
  // req_write[i] is only sampled on the grant edge. PREADY from the UART ends a
  // transfer; transfer is a one-cycle start strobe and gnt stays one-hot until done/err.
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] req_write;
  logic               uart_run_flag;
  logic               PREADY;
  logic               transfer;
  logic               PWRITE;
  logic [1:0]         ctrl;
  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] done;
  logic [NUM_REQ-1:0] err;
  logic               busy;

  modport slave (
    input  req, req_write, uart_run_flag, PREADY,
    output transfer, PWRITE, ctrl, gnt, done, err, busy
  );

  modport master (
    output req, req_write, uart_run_flag, PREADY,
    input  transfer, PWRITE, ctrl, gnt, done, err, busy
  );

endinterface

// File: rtl/uart_req_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request strictly after rr_ptr,
// wrapping modulo NUM_REQ, so the last-served requester ranks lowest.
module rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               valid
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    cand   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (!valid && req[cand]) begin
        valid  = 1'b1;
        winner = cand;
      end
    end
  end

endmodule

// File: rtl/uart_req_arbiter.sv
// Round-robin arbiter sharing one UART transfer FSM between NUM_REQ requesters.
// All outputs are registered; ISSUE launches the strobe, WAIT watches PREADY/timeout.
module uart_req_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                     PCLK,
  input  logic                     PRESET,
  uart_req_arbiter_if.slave        bus,
  output arb_state_e               dbg_state
);

  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [NUM_REQ-1:0] err_q, err_d;
  logic               transfer_q, transfer_d;
  logic               pwrite_q, pwrite_d;
  logic [1:0]         ctrl_q, ctrl_d;
  logic [TO_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   win_q, win_d;
  logic               dir_q, dir_d;

  logic [IDX_W-1:0]   pick_win;
  logic               pick_valid;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .req    (bus.req),
    .rr_ptr (rr_ptr_q),
    .winner (pick_win),
    .valid  (pick_valid)
  );

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    done_d     = '0;
    err_d      = '0;
    transfer_d = 1'b0;
    pwrite_d   = pwrite_q;
    ctrl_d     = ctrl_q;
    cnt_d      = cnt_q;
    rr_ptr_d   = rr_ptr_q;
    win_d      = win_q;
    dir_d      = dir_q;

    unique case (state_q)
      IDLE: begin
        if (bus.uart_run_flag && pick_valid) begin
          gnt_d   = NUM_REQ'(1) << pick_win;
          win_d   = pick_win;
          dir_d   = bus.req_write[pick_win];
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        transfer_d = 1'b1;
        pwrite_d   = dir_q;
        ctrl_d     = ctrl_for_dir(dir_q);
        cnt_d      = '0;
        state_d    = WAIT;
      end

      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // Completion beats timeout, which beats a run-flag abort.
        if (bus.PREADY) begin
          done_d   = gnt_q;
          rr_ptr_d = win_q;
          state_d  = CLEAR;
        end else if (cnt_q == TO_W'(TIMEOUT_CYC)) begin
          err_d    = gnt_q;
          rr_ptr_d = win_q;
          state_d  = CLEAR;
        end else if (!bus.uart_run_flag) begin
          err_d    = gnt_q;
          rr_ptr_d = win_q;
          state_d  = CLEAR;
        end
      end

      CLEAR: begin
        gnt_d    = '0;
        ctrl_d   = CTRL_NONE;
        pwrite_d = 1'b0;
        state_d  = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      done_q     <= '0;
      err_q      <= '0;
      transfer_q <= 1'b0;
      pwrite_q   <= 1'b0;
      ctrl_q     <= CTRL_NONE;
      cnt_q      <= '0;
      rr_ptr_q   <= IDX_W'(NUM_REQ - 1);
      win_q      <= '0;
      dir_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
      transfer_q <= transfer_d;
      pwrite_q   <= pwrite_d;
      ctrl_q     <= ctrl_d;
      cnt_q      <= cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      win_q      <= win_d;
      dir_q      <= dir_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.transfer = transfer_q;
  assign bus.PWRITE   = pwrite_q;
  assign bus.ctrl     = ctrl_q;
  assign bus.busy     = (state_q != IDLE);
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_uart_req_arbiter.sv
// Self-checking bench for uart_req_arbiter: transaction-level model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_uart_req_arbiter;
  import uart_arb_pkg::*;

  localparam int NUM_REQ     = 4;
  localparam int TIMEOUT_CYC = 15;

  logic       PCLK;
  logic       PRESET;
  arb_state_e dbg_state;

  uart_req_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  uart_req_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge PCLK);
    #2;
  endtask

  // ---------------- behavioural model ----------------
  // A transaction is tracked as: who holds the grant, its captured direction,
  // how many edges have passed since the grant, and whether it has finished.
  bit                 model_ready = 1'b0;
  bit                 m_active    = 1'b0;
  int                 m_who       = 0;
  bit                 m_dir       = 1'b0;
  int                 m_since     = 0;
  bit                 m_fin       = 1'b0;
  int                 m_last      = NUM_REQ - 1;
  logic [NUM_REQ-1:0] m_done      = '0;
  logic [NUM_REQ-1:0] m_err       = '0;

  function automatic int pick_next(input logic [NUM_REQ-1:0] r, input int last);
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (r[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
    end
    return -1;
  endfunction

  always @(posedge PCLK) begin
    m_done = '0;
    m_err  = '0;
    if (PRESET) begin
      model_ready = 1'b1;
      m_active    = 1'b0;
      m_fin       = 1'b0;
      m_since     = 0;
      m_last      = NUM_REQ - 1;
    end else if (!m_active) begin
      if (bus.uart_run_flag && (|bus.req)) begin
        m_who    = pick_next(bus.req, m_last);
        m_dir    = bus.req_write[m_who];
        m_active = 1'b1;
        m_since  = 0;
        m_fin    = 1'b0;
      end
    end else if (m_fin) begin
      m_active = 1'b0;
    end else if (m_since == 0) begin
      m_since = 1;
    end else begin
      // m_since-1 cycles have elapsed in the waiting phase
      if (bus.PREADY) begin
        m_done[m_who] = 1'b1;
        m_fin = 1'b1;
        m_last = m_who;
      end else if (m_since - 1 == TIMEOUT_CYC || !bus.uart_run_flag) begin
        m_err[m_who] = 1'b1;
        m_fin = 1'b1;
        m_last = m_who;
      end else begin
        m_since++;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [NUM_REQ-1:0] e_gnt;
  logic [1:0]         e_ctrl;
  logic               e_pwrite, e_transfer;

  always @(negedge PCLK) begin
    if (model_ready) begin
      e_gnt      = m_active ? (NUM_REQ'(1) << m_who) : '0;
      e_transfer = m_active && !m_fin && (m_since == 1);
      e_pwrite   = m_active && (m_since >= 1) && m_dir;
      e_ctrl     = (m_active && m_since >= 1) ? (m_dir ? 2'b01 : 2'b10) : 2'b00;
      check("cyc_outputs",
            {bus.gnt, bus.done, bus.err, bus.transfer, bus.PWRITE, bus.ctrl, bus.busy},
            {e_gnt, m_done, m_err, e_transfer, e_pwrite, e_ctrl, m_active});
      check("cyc_state_busy", 32'(dbg_state != IDLE), 32'(m_active));
      check("cyc_gnt_onehot0", 32'($onehot0(bus.gnt)), 32'd1);
      check("cyc_done_err_excl", 32'(|(bus.done & bus.err)), 32'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    PRESET = 1'b1;
    step();
    step();
    PRESET = 1'b0;
  endtask

  task automatic wait_transfer(input string name);
    for (int i = 0; i < 60; i++) begin
      if (bus.transfer === 1'b1) return;
      step();
    end
    check({name, "_transfer_timeout"}, 32'd0, 32'd1);
  endtask

  logic [NUM_REQ-1:0] exp_gnt_tbl [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [1:0]         exp_ctrl_tbl[5] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int n;
    PRESET            = 1'b1;
    bus.req           = '0;
    bus.req_write     = '0;
    bus.uart_run_flag = 1'b0;
    bus.PREADY        = 1'b0;
    do_reset();
    check("rst_outputs",
          {bus.gnt, bus.done, bus.err, bus.transfer, bus.PWRITE, bus.ctrl, bus.busy}, 32'd0);

    // Single write transaction from requester 0
    bus.uart_run_flag = 1'b1;
    bus.req           = 4'b0001;
    bus.req_write     = 4'b0001;
    step();
    check("t1_gnt", bus.gnt, 4'b0001);
    check("t1_no_transfer_yet", bus.transfer, 1'b0);
    step();
    check("t1_transfer", {bus.transfer, bus.PWRITE, bus.ctrl}, 4'b1101);
    step();
    step();
    step();
    bus.PREADY = 1'b1;
    step();
    bus.PREADY = 1'b0;
    bus.req    = '0;
    check("t1_done", {bus.done, bus.gnt}, 8'b0001_0001);
    step();
    check("t1_gnt_clear", {bus.gnt, bus.busy}, 5'b0);

    // Round robin with all requesters held
    do_reset();
    bus.req       = 4'b1111;
    bus.req_write = 4'b0101;
    for (int t = 0; t < 5; t++) begin
      wait_transfer("t2");
      check("t2_gnt_order", bus.gnt, exp_gnt_tbl[t]);
      check("t2_ctrl", bus.ctrl, exp_ctrl_tbl[t]);
      step();
      bus.PREADY = 1'b1;
      step();
      bus.PREADY = 1'b0;
      check("t2_done", bus.done, exp_gnt_tbl[t]);
    end
    bus.req = '0;
    step();

    // Timeout on requester 2
    bus.req       = 4'b0100;
    bus.req_write = 4'b0000;
    wait_transfer("t3");
    check("t3_gnt", bus.gnt, 4'b0100);
    n = 0;
    while (bus.err == '0 && n < 40) begin
      step();
      n++;
    end
    check("t3_err_latency", n, 16);
    check("t3_err", {bus.err, bus.done}, 8'b0100_0000);
    bus.req = 4'b1111;
    wait_transfer("t3b");
    check("t3_next_gnt", bus.gnt, 4'b1000);
    step();
    bus.PREADY = 1'b1;
    step();
    bus.PREADY = 1'b0;
    bus.req    = '0;
    check("t3_next_done", bus.done, 4'b1000);
    step();

    // PREADY arriving on the timeout cycle; requester misbehaves while granted
    bus.req       = 4'b0010;
    bus.req_write = 4'b0000;
    wait_transfer("t4");
    check("t4_ctrl", bus.ctrl, 2'b10);
    bus.req_write = 4'b0010;
    bus.req       = '0;
    for (int i = 0; i < TIMEOUT_CYC; i++) step();
    bus.PREADY = 1'b1;
    step();
    bus.PREADY = 1'b0;
    check("t4_done_wins", {bus.done, bus.err}, 8'b0010_0000);
    step();
    step();

    // Run flag dropped in WAIT
    bus.req       = 4'b0001;
    bus.req_write = 4'b0001;
    wait_transfer("t5");
    step();
    step();
    step();
    bus.uart_run_flag = 1'b0;
    step();
    check("t5_abort_err", {bus.err, bus.done}, 8'b0001_0000);
    bus.req = 4'b1111;
    step();
    check("t5_idle", {bus.gnt, bus.busy}, 5'b0);
    for (int i = 0; i < 5; i++) step();
    check("t5_no_grant", bus.gnt, 4'b0000);

    // Reset in the middle of WAIT
    bus.uart_run_flag = 1'b1;
    wait_transfer("t6");
    check("t6_gnt", bus.gnt, 4'b0010);
    step();
    step();
    PRESET = 1'b1;
    step();
    check("t6_reset_outputs",
          {bus.gnt, bus.transfer, bus.ctrl, bus.busy, bus.done, bus.err}, 32'd0);
    PRESET = 1'b0;
    step();
    check("t6_first_gnt", bus.gnt, 4'b0001);
    wait_transfer("t6b");
    step();
    bus.PREADY = 1'b1;
    step();
    bus.PREADY = 1'b0;
    bus.req    = '0;
    check("t6_done", bus.done, 4'b0001);
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
